// File: rtl/obi_axi_bridge_mo.sv
// OBI-to-AXI4 master bridge with multiple outstanding transactions.
// Responses return to OBI strictly in request order.
module obi_axi_bridge_mo #(
    parameter int ADDR_WIDTH      = 32,
    parameter int OBI_DATA_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 128,
    parameter int AXI_ID_WIDTH    = 3,
    parameter int AXI_ID          = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    // OBI side
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic [ADDR_WIDTH-1:0]       addr_i,
    input  logic                        we_i,
    input  logic [OBI_DATA_WIDTH/8-1:0] be_i,
    input  logic [OBI_DATA_WIDTH-1:0]   wdata_i,
    output logic                        rvalid_o,
    output logic [OBI_DATA_WIDTH-1:0]   rdata_o,
    output logic                        err_o,
    // AXI write address
    output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
    output logic [ADDR_WIDTH-1:0]       aw_addr_o,
    output logic [7:0]                  aw_len_o,
    output logic [2:0]                  aw_size_o,
    output logic [1:0]                  aw_burst_o,
    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    // AXI write data
    output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
    output logic                        w_last_o,
    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    // AXI write response
    input  logic [AXI_ID_WIDTH-1:0]     b_id_i,
    input  logic [1:0]                  b_resp_i,
    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    // AXI read address
    output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
    output logic [ADDR_WIDTH-1:0]       ar_addr_o,
    output logic [7:0]                  ar_len_o,
    output logic [2:0]                  ar_size_o,
    output logic [1:0]                  ar_burst_o,
    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    // AXI read data
    input  logic [AXI_ID_WIDTH-1:0]     r_id_i,
    input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
    input  logic [1:0]                  r_resp_i,
    input  logic                        r_last_i,
    input  logic                        r_valid_i,
    output logic                        r_ready_o
);

    localparam int OBI_BYTES = OBI_DATA_WIDTH / 8;
    localparam int AXI_BYTES = AXI_DATA_WIDTH / 8;
    localparam int LANES     = AXI_DATA_WIDTH / OBI_DATA_WIDTH;
    localparam int OFF_W     = $clog2(OBI_BYTES);
    localparam int LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTR_W     = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [2:0]            SIZE      = 3'(OFF_W);
    localparam logic [1:0]            BURST     = 2'b01;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(OBI_BYTES - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(MAX_OUTSTANDING - 1);

    // Command register
    logic                      r_cmd_valid;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic                      r_we;
    logic [OBI_BYTES-1:0]      r_be;
    logic [OBI_DATA_WIDTH-1:0] r_wdata;
    logic [LANE_W-1:0]         r_lane;
    logic                      r_aw_sent;
    logic                      r_w_sent;

    // Order FIFO entries are {we, lane}
    logic [LANE_W:0]           r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_cnt;

    // Response register
    logic                      r_rvalid;
    logic [OBI_DATA_WIDTH-1:0] r_rdata;
    logic                      r_err;

    logic [LANE_W-1:0]         w_lane;
    logic                      w_fifo_full;
    logic                      w_head_valid;
    logic [LANE_W:0]           w_head;
    logic                      w_head_we;
    logic [LANE_W-1:0]         w_head_lane;
    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_ar_hs;
    logic                      w_aw_done;
    logic                      w_w_done;
    logic                      w_cmd_done;
    logic                      w_b_hs;
    logic                      w_r_hs;
    logic                      w_retire;
    logic [AXI_DATA_WIDTH-1:0] w_r_shifted;
    logic [AXI_BYTES-1:0]      w_strb_full;
    logic                      w_unused;

    // IDs, last and the low response bit carry no information here.
    assign w_unused = ^{b_id_i, r_id_i, r_last_i, b_resp_i[0], r_resp_i[0]};

    generate
        if (LANES > 1) begin : g_lane
            assign w_lane = addr_i[OFF_W + LANE_W - 1 : OFF_W];
        end else begin : g_nolane
            assign w_lane = '0;
        end
    endgenerate

    assign w_fifo_full  = (r_cnt == CNT_MAX);
    assign w_head_valid = (r_cnt != '0);
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_head_we    = w_head[LANE_W];
    assign w_head_lane  = w_head[LANE_W-1:0];

    assign gnt_o = req_i && !r_cmd_valid && (r_cnt < CNT_MAX) && !w_fifo_full;

    // Request channels
    assign aw_valid_o = r_cmd_valid && r_we && !r_aw_sent;
    assign w_valid_o  = r_cmd_valid && r_we && !r_w_sent;
    assign ar_valid_o = r_cmd_valid && !r_we;

    assign w_aw_hs    = aw_valid_o && aw_ready_i;
    assign w_w_hs     = w_valid_o && w_ready_i;
    assign w_ar_hs    = ar_valid_o && ar_ready_i;
    assign w_aw_done  = r_aw_sent || w_aw_hs;
    assign w_w_done   = r_w_sent || w_w_hs;
    assign w_cmd_done = r_we ? (w_aw_done && w_w_done) : w_ar_hs;

    assign w_strb_full = AXI_BYTES'(r_be) << (32'(r_lane) * 32'(OBI_BYTES));

    assign aw_id_o    = AXI_ID_WIDTH'(AXI_ID);
    assign aw_addr_o  = aw_valid_o ? (r_addr & ADDR_MASK) : '0;
    assign aw_len_o   = '0;
    assign aw_size_o  = aw_valid_o ? SIZE : '0;
    assign aw_burst_o = aw_valid_o ? BURST : '0;

    assign w_data_o   = w_valid_o ? {LANES{r_wdata}} : '0;
    assign w_strb_o   = w_valid_o ? w_strb_full : '0;
    assign w_last_o   = w_valid_o;

    assign ar_id_o    = AXI_ID_WIDTH'(AXI_ID);
    assign ar_addr_o  = ar_valid_o ? (r_addr & ADDR_MASK) : '0;
    assign ar_len_o   = '0;
    assign ar_size_o  = ar_valid_o ? SIZE : '0;
    assign ar_burst_o = ar_valid_o ? BURST : '0;

    // Response acceptance follows the order FIFO head only
    assign b_ready_o = w_head_valid && w_head_we;
    assign r_ready_o = w_head_valid && !w_head_we;

    assign w_b_hs   = b_valid_i && b_ready_o;
    assign w_r_hs   = r_valid_i && r_ready_o;
    assign w_retire = w_b_hs || w_r_hs;

    assign w_r_shifted = r_data_i >> (32'(w_head_lane) * 32'(OBI_DATA_WIDTH));

    assign rvalid_o = r_rvalid;
    assign rdata_o  = r_rdata;
    assign err_o    = r_err;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Command register: load on grant, free once every channel handshook
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cmd_valid <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_lane      <= '0;
            r_aw_sent   <= 1'b0;
            r_w_sent    <= 1'b0;
        end else if (gnt_o) begin
            r_cmd_valid <= 1'b1;
            r_addr      <= addr_i;
            r_we        <= we_i;
            r_be        <= be_i;
            r_wdata     <= wdata_i;
            r_lane      <= w_lane;
            r_aw_sent   <= 1'b0;
            r_w_sent    <= 1'b0;
        end else if (r_cmd_valid) begin
            if (w_cmd_done) begin
                r_cmd_valid <= 1'b0;
                r_aw_sent   <= 1'b0;
                r_w_sent    <= 1'b0;
            end else begin
                r_aw_sent   <= w_aw_done;
                r_w_sent    <= w_w_done;
            end
        end
    end

    // Order FIFO storage: written on grant, no reset needed
    always_ff @(posedge clk_i) begin
        if (gnt_o) begin
            r_fifo[r_wr_ptr] <= {we_i, w_lane};
        end
    end

    // Order FIFO pointers and outstanding count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (gnt_o) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_retire) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (gnt_o && !w_retire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!gnt_o && w_retire) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // OBI response: one-cycle pulse after each retiring B or R
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_retire;
            r_rdata  <= w_r_hs ? w_r_shifted[OBI_DATA_WIDTH-1:0] : '0;
            r_err    <= w_b_hs ? b_resp_i[1] : (w_r_hs ? r_resp_i[1] : 1'b0);
        end
    end

endmodule

// File: tb/tb_obi_axi_bridge_mo.sv
// Scoreboard bench for obi_axi_bridge_mo.
// Expected OBI responses are queued at grant and checked by a monitor.
module tb_obi_axi_bridge_mo;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_i;
    logic         gnt_o;
    logic [31:0]  addr_i;
    logic         we_i;
    logic [3:0]   be_i;
    logic [31:0]  wdata_i;
    logic         rvalid_o;
    logic [31:0]  rdata_o;
    logic         err_o;
    logic [2:0]   aw_id_o;
    logic [31:0]  aw_addr_o;
    logic [7:0]   aw_len_o;
    logic [2:0]   aw_size_o;
    logic [1:0]   aw_burst_o;
    logic         aw_valid_o;
    logic         aw_ready_i;
    logic [127:0] w_data_o;
    logic [15:0]  w_strb_o;
    logic         w_last_o;
    logic         w_valid_o;
    logic         w_ready_i;
    logic [2:0]   b_id_i;
    logic [1:0]   b_resp_i;
    logic         b_valid_i;
    logic         b_ready_o;
    logic [2:0]   ar_id_o;
    logic [31:0]  ar_addr_o;
    logic [7:0]   ar_len_o;
    logic [2:0]   ar_size_o;
    logic [1:0]   ar_burst_o;
    logic         ar_valid_o;
    logic         ar_ready_i;
    logic [2:0]   r_id_i;
    logic [127:0] r_data_i;
    logic [1:0]   r_resp_i;
    logic         r_last_i;
    logic         r_valid_i;
    logic         r_ready_o;

    localparam logic [127:0] RD = {32'h44444444, 32'h33333333,
                                   32'h22222222, 32'h11111111};

    int total = 0;
    int bad   = 0;
    logic [32:0] sb_q [$];

    always #5 clk_i = ~clk_i;

    obi_axi_bridge_mo #(
        .ADDR_WIDTH(32), .OBI_DATA_WIDTH(32), .AXI_DATA_WIDTH(128),
        .AXI_ID_WIDTH(3), .AXI_ID(0), .MAX_OUTSTANDING(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
        .be_i(be_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
        .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o),
        .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_id_i(b_id_i), .b_resp_i(b_resp_i), .b_valid_i(b_valid_i),
        .b_ready_o(b_ready_o),
        .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o),
        .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_id_i(r_id_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i),
        .r_last_i(r_last_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Issue one OBI request; queue its expected response on grant.
    task automatic obi_req(input logic [31:0] a, input logic we,
                           input logic [3:0] be, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input logic exp_err);
        bit got;
        got = 1'b0;
        req_i   = 1'b1;
        addr_i  = a;
        we_i    = we;
        be_i    = be;
        wdata_i = wd;
        for (int k = 0; k < 50 && !got; k++) begin
            #1;
            if (gnt_o) begin
                got = 1'b1;
                sb_q.push_back({exp_err, exp_rd});
            end
            @(posedge clk_i);
            #1;
        end
        req_i = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL obi_gnt_timeout addr=%0h", a);
        end
    endtask

    // Monitor: every OBI response pops and compares the queue head.
    always @(negedge clk_i) begin
        logic [32:0] e;
        if (!rst_i && rvalid_o) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp actual=%0h required=none",
                         rdata_o);
            end else begin
                e = sb_q.pop_front();
                chk("rsp_rdata", 128'(rdata_o), 128'(e[31:0]));
                chk("rsp_err", 128'(err_o), 128'(e[32]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int idx;
        int ng;
        int naw;
        int nw;
        int ngnt;

        rst_i = 1'b1;
        req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
        aw_ready_i = 1'b0; w_ready_i = 1'b0; ar_ready_i = 1'b0;
        b_id_i = '0; b_resp_i = '0; b_valid_i = 1'b0;
        r_id_i = '0; r_data_i = '0; r_resp_i = '0;
        r_last_i = 1'b0; r_valid_i = 1'b0;
        step(3);
        chk("rst_outs", 128'({gnt_o, rvalid_o, err_o, aw_valid_o, w_valid_o,
                              ar_valid_o, b_ready_o, r_ready_o, w_last_o}), 0);
        chk("rst_data", 128'({rdata_o, aw_addr_o, ar_addr_o, w_strb_o,
                              aw_size_o, ar_size_o}), 0);
        rst_i = 1'b0;
        step(1);

        // Single write into lane 1
        obi_req(32'h1004, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        chk("t1_aw", 128'({aw_valid_o, aw_addr_o, aw_len_o, aw_size_o,
                           aw_burst_o}), 128'({1'b1, 32'h1004, 8'd0, 3'd2, 2'b01}));
        chk("t1_w", 128'({w_valid_o, w_last_o, w_strb_o}),
            128'({1'b1, 1'b1, 16'h00F0}));
        chk("t1_wdata", w_data_o, {4{32'hDEADBEEF}});
        chk("t1_ar_idle", 128'(ar_valid_o), 0);
        aw_ready_i = 1'b1; w_ready_i = 1'b1;
        step(1);
        aw_ready_i = 1'b0; w_ready_i = 1'b0;
        chk("t1_valids_drop", 128'({aw_valid_o, w_valid_o}), 0);
        b_valid_i = 1'b1; b_resp_i = 2'b00;
        #1 chk("t1_bready", 128'(b_ready_o), 1);
        step(1);
        b_valid_i = 1'b0;
        step(3);
        chk("t1_drain", 128'(sb_q.size()), 0);

        // Read from lane 3
        obi_req(32'h200C, 1'b0, 4'hF, 32'h0, 32'h44444444, 1'b0);
        chk("t2_ar", 128'({ar_valid_o, ar_addr_o, ar_len_o, ar_size_o,
                           ar_burst_o}), 128'({1'b1, 32'h200C, 8'd0, 3'd2, 2'b01}));
        ar_ready_i = 1'b1;
        step(1);
        ar_ready_i = 1'b0;
        r_valid_i = 1'b1; r_data_i = RD; r_resp_i = 2'b00; r_last_i = 1'b1;
        #1 chk("t2_rready", 128'(r_ready_o), 1);
        step(1);
        r_valid_i = 1'b0;
        step(3);
        chk("t2_drain", 128'(sb_q.size()), 0);

        // Six back-to-back reads against a limit of four
        ar_ready_i = 1'b1;
        idx = 0;
        ng  = 0;
        for (int c = 0; c < 20; c++) begin
            req_i  = (idx < 6);
            addr_i = 32'h3000 + 32'(idx * 4);
            we_i   = 1'b0;
            be_i   = 4'hF;
            #1;
            if (gnt_o) begin
                sb_q.push_back({1'b0, 32'h11111111 * 32'((idx % 4) + 1)});
                idx++;
                ng++;
            end
            @(posedge clk_i);
            #1;
        end
        chk("t3_grants_at_limit", 128'(ng), 4);
        #1 chk("t3_gnt_held_low", 128'(gnt_o), 0);
        r_valid_i = 1'b1; r_data_i = RD; r_resp_i = 2'b00;
        step(1);
        r_valid_i = 1'b0;
        #1 chk("t3_regrant_after_retire", 128'(gnt_o), 1);
        r_valid_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            req_i  = (idx < 6);
            addr_i = 32'h3000 + 32'(idx * 4);
            #1;
            if (gnt_o) begin
                sb_q.push_back({1'b0, 32'h11111111 * 32'((idx % 4) + 1)});
                idx++;
                ng++;
            end
            @(posedge clk_i);
            #1;
        end
        r_valid_i = 1'b0;
        req_i = 1'b0;
        ar_ready_i = 1'b0;
        chk("t3_total_grants", 128'(ng), 6);
        step(3);
        chk("t3_drain", 128'(sb_q.size()), 0);

        // Write then read; slave offers R before B
        aw_ready_i = 1'b1; w_ready_i = 1'b1; ar_ready_i = 1'b1;
        obi_req(32'h4000, 1'b1, 4'h3, 32'hCAFE1234, 32'h0, 1'b0);
        obi_req(32'h4008, 1'b0, 4'hF, 32'h0, 32'h33333333, 1'b0);
        step(1);
        aw_ready_i = 1'b0; w_ready_i = 1'b0; ar_ready_i = 1'b0;
        r_valid_i = 1'b1; r_data_i = RD; r_resp_i = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1 chk("t4_r_stalled", 128'(r_ready_o), 0);
            step(1);
        end
        b_valid_i = 1'b1; b_resp_i = 2'b00;
        #1 chk("t4_bready", 128'(b_ready_o), 1);
        step(1);
        b_valid_i = 1'b0;
        #1 chk("t4_rready_after_b", 128'(r_ready_o), 1);
        step(1);
        r_valid_i = 1'b0;
        step(3);
        chk("t4_drain", 128'(sb_q.size()), 0);

        // Write with W accepted five cycles after AW
        aw_ready_i = 1'b1; w_ready_i = 1'b0;
        obi_req(32'h5008, 1'b1, 4'hC, 32'h5555AAAA, 32'h0, 1'b0);
        chk("t5_strb", 128'(w_strb_o), 128'(16'h0C00));
        chk("t5_wdata", w_data_o, {4{32'h5555AAAA}});
        naw = 0; nw = 0; ngnt = 0;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h5000;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (aw_valid_o && aw_ready_i) naw++;
            if (w_valid_o && w_ready_i) nw++;
            if (gnt_o) ngnt++;
            @(posedge clk_i);
            #1;
        end
        req_i = 1'b0;
        w_ready_i = 1'b1;
        #1;
        if (aw_valid_o && aw_ready_i) naw++;
        if (w_valid_o && w_ready_i) nw++;
        step(1);
        aw_ready_i = 1'b0; w_ready_i = 1'b0;
        chk("t5_aw_count", 128'(naw), 1);
        chk("t5_w_count", 128'(nw), 1);
        chk("t5_no_regrant", 128'(ngnt), 0);
        chk("t5_valids_drop", 128'({aw_valid_o, w_valid_o}), 0);
        b_valid_i = 1'b1; b_resp_i = 2'b00;
        step(1);
        b_valid_i = 1'b0;
        step(3);
        chk("t5_drain", 128'(sb_q.size()), 0);

        // SLVERR on a read
        ar_ready_i = 1'b1;
        obi_req(32'h6004, 1'b0, 4'hF, 32'h0, 32'h22222222, 1'b1);
        step(1);
        r_valid_i = 1'b1; r_data_i = RD; r_resp_i = 2'b10;
        step(1);
        r_valid_i = 1'b0; r_resp_i = 2'b00;
        step(3);
        chk("t6_drain", 128'(sb_q.size()), 0);

        // Reset with three reads outstanding
        obi_req(32'h7000, 1'b0, 4'hF, 32'h0, 32'h11111111, 1'b0);
        obi_req(32'h7004, 1'b0, 4'hF, 32'h0, 32'h22222222, 1'b0);
        obi_req(32'h7008, 1'b0, 4'hF, 32'h0, 32'h33333333, 1'b0);
        step(1);
        chk("t7_cnt_before", 128'(dut.r_cnt), 3);
        rst_i = 1'b1;
        step(1);
        sb_q.delete();
        chk("t7_cnt_after", 128'(dut.r_cnt), 0);
        chk("t7_valids", 128'({aw_valid_o, w_valid_o, ar_valid_o, rvalid_o,
                               b_ready_o, r_ready_o}), 0);
        req_i = 1'b1;
        #1 chk("t7_gnt_follows_req_hi", 128'(gnt_o), 1);
        req_i = 1'b0;
        #1 chk("t7_gnt_follows_req_lo", 128'(gnt_o), 0);
        rst_i = 1'b0;
        step(1);
        obi_req(32'h7004, 1'b0, 4'hF, 32'h0, 32'h22222222, 1'b0);
        step(1);
        r_valid_i = 1'b1; r_data_i = RD; r_resp_i = 2'b00;
        step(1);
        r_valid_i = 1'b0;
        ar_ready_i = 1'b0;
        step(3);
        chk("t7_drain", 128'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
